// File: rtl/aib_link_bringup_ctrl_if.sv
// MAC-side control and status pins between the bring-up sequencer and one AIB channel.
`timescale 1ns/1ps
interface aib_link_bringup_ctrl_if;
  logic config_done;
  logic device_detect;
  logic por;
  logic adapter_rstn;
  logic mac_rdy;
  logic tx_lock_req;
  logic rx_lock_req;
  logic tx_transfer_en;
  logic rx_transfer_en;
  logic fs_mac_rdy;

  modport master (
    output config_done, device_detect, por, adapter_rstn, mac_rdy, tx_lock_req, rx_lock_req,
    input  tx_transfer_en, rx_transfer_en, fs_mac_rdy
  );

  modport slave (
    input  config_done, device_detect, por, adapter_rstn, mac_rdy, tx_lock_req, rx_lock_req,
    output tx_transfer_en, rx_transfer_en, fs_mac_rdy
  );
endinterface

// File: rtl/aib_link_bringup_ctrl.sv
// Per-channel AIB bring-up/retrain sequencer: orders config, reset release and lock requests,
// watches transfer enables, and retries a bounded number of times before parking in ERROR.
`timescale 1ns/1ps
module aib_link_bringup_ctrl #(
  parameter int PWR_WAIT   = 20,
  parameter int CFG_WAIT   = 10,
  parameter int RST_WAIT   = 12,
  parameter int RXLOCK_DLY = 20,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      retrain,
  input  logic                      ms_nsl,
  aib_link_bringup_ctrl_if.master   aib,
  output logic                      link_up,
  output logic                      link_err,
  output logic [1:0]                retry_cnt,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PWRUP   = 3'd1,
    CFG     = 3'd2,
    RSTREL  = 3'd3,
    LOCK    = 3'd4,
    LINK_UP = 3'd5,
    RETRAIN = 3'd6,
    ERROR   = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(CFG_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RX_DLY    = CNT_W'(RXLOCK_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       tx_sync, rx_sync, fs_sync;
  logic             fs_prev;
  logic             xfer, fs_fall, retrain_req;
  logic             cfg_on, run_on, lock_on, rx_on;
  logic             config_done_q, detect_q, por_q, adapter_rstn_q, mac_rdy_q;
  logic             tx_lock_q, rx_lock_q, link_up_q, link_err_q;

  // Channel status arrives asynchronously; fs_prev lets LINK_UP see a far-side ready drop as an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sync <= '0;
      rx_sync <= '0;
      fs_sync <= '0;
      fs_prev <= 1'b0;
    end else begin
      tx_sync <= {tx_sync[0], aib.tx_transfer_en};
      rx_sync <= {rx_sync[0], aib.rx_transfer_en};
      fs_sync <= {fs_sync[0], aib.fs_mac_rdy};
      fs_prev <= fs_sync[1];
    end
  end

  assign xfer    = tx_sync[1] & rx_sync[1];
  assign fs_fall = fs_prev & ~fs_sync[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      retry_q        <= '0;
      config_done_q  <= 1'b0;
      detect_q       <= 1'b0;
      por_q          <= 1'b0;
      adapter_rstn_q <= 1'b0;
      mac_rdy_q      <= 1'b0;
      tx_lock_q      <= 1'b0;
      rx_lock_q      <= 1'b0;
      link_up_q      <= 1'b0;
      link_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      config_done_q  <= cfg_on;
      detect_q       <= cfg_on & ms_nsl;
      por_q          <= cfg_on & ~ms_nsl;
      adapter_rstn_q <= run_on;
      mac_rdy_q      <= run_on;
      tx_lock_q      <= lock_on;
      rx_lock_q      <= rx_on;
      link_up_q      <= (state_d == LINK_UP);
      link_err_q     <= (state_d == ERROR);
    end
  end

  // Outputs are decoded from the next state so every pin moves on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    retrain_req = 1'b0;

    case (state_q)
      IDLE:    if (start) state_d = PWRUP;
      PWRUP:   if (cnt_q == PWR_LAST) state_d = CFG;
      CFG:     if (cnt_q == CFG_LAST) state_d = RSTREL;
      RSTREL:  if (cnt_q == RST_LAST) state_d = LOCK;
      LOCK: begin
        if (xfer)                   state_d = LINK_UP;
        else if (cnt_q == TO_LAST)  retrain_req = 1'b1;
      end
      LINK_UP: if (retrain || !xfer || fs_fall) retrain_req = 1'b1;
      RETRAIN: if (cnt_q == RST_LAST) state_d = RSTREL;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // Every retrain trigger funnels here so the attempt budget is charged exactly once.
    if (retrain_req) begin
      if (retry_q == RETRY_MAX) begin
        state_d = ERROR;
      end else begin
        state_d = RETRAIN;
        if (retry_q != 2'b11) retry_d = retry_q + 2'd1;
      end
    end

    if (!start) begin
      state_d = IDLE;
      retry_d = '0;
    end

    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    else                       cnt_d = cnt_q;

    cfg_on  = state_d inside {CFG, RSTREL, LOCK, LINK_UP, RETRAIN, ERROR};
    run_on  = state_d inside {RSTREL, LOCK, LINK_UP};
    lock_on = state_d inside {LOCK, LINK_UP};
    rx_on   = (state_d == LINK_UP) || ((state_d == LOCK) && (ms_nsl || (cnt_d >= RX_DLY)));
  end

  assign aib.config_done   = config_done_q;
  assign aib.device_detect = detect_q;
  assign aib.por           = por_q;
  assign aib.adapter_rstn  = adapter_rstn_q;
  assign aib.mac_rdy       = mac_rdy_q;
  assign aib.tx_lock_req   = tx_lock_q;
  assign aib.rx_lock_req   = rx_lock_q;
  assign link_up           = link_up_q;
  assign link_err          = link_err_q;
  assign retry_cnt         = retry_q;
  assign state             = state_q;

endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
// Bench for aib_link_bringup_ctrl: directed bring-up/retrain scenarios plus a random soak,
// all checked every cycle against a phase-and-elapsed-time model of the sequencer.
`timescale 1ns/1ps
module tb_aib_link_bringup_ctrl;
  localparam int PWR_WAIT   = 20;
  localparam int CFG_WAIT   = 10;
  localparam int RST_WAIT   = 12;
  localparam int RXLOCK_DLY = 20;
  localparam int TIMEOUT    = 1024;
  localparam int MAX_RETRY  = 3;
  localparam int CNT_W      = 16;
  localparam int HIST       = 16384;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start, retrain, ms_nsl;
  logic       link_up, link_err;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  aib_link_bringup_ctrl_if aib();

  aib_link_bringup_ctrl #(
    .PWR_WAIT(PWR_WAIT), .CFG_WAIT(CFG_WAIT), .RST_WAIT(RST_WAIT), .RXLOCK_DLY(RXLOCK_DLY),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .retrain(retrain), .ms_nsl(ms_nsl), .aib(aib),
    .link_up(link_up), .link_err(link_err), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic m,
                               input logic t, input logic x, input logic f);
    start = s; retrain = r; ms_nsl = m;
    aib.tx_transfer_en = t; aib.rx_transfer_en = x; aib.fs_mac_rdy = f;
  endtask

  function automatic logic [13:0] dut_vec();
    return {state, retry_cnt, aib.config_done, aib.device_detect, aib.por, aib.adapter_rstn,
            aib.mac_rdy, aib.tx_lock_req, aib.rx_lock_req, link_up, link_err};
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return aib.tx_lock_req;
      1:       return aib.rx_lock_req;
      2:       return link_up;
      3:       return link_err;
      default: return aib.adapter_rstn;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input logic level, input int limit, output int n);
    n = 0;
    while (pick(sel) !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_reached"}, 32'(pick(sel)), 32'(level));
  endtask

  // Model: phase numbers follow the state encoding; timing is "edges since the phase began".
  int          cyc, last_rst, m_pe, m_phase, m_retry;
  logic [13:0] exp_vec;
  bit          hist [3][HIST];

  function automatic bit raw(input int ch, input int k);
    if (k <= last_rst) return 1'b0;
    return hist[ch][k % HIST];
  endfunction

  initial begin : model
    int nxt, d;
    bit xfer, fall, lose, cd, ar, tx, rx;
    cyc = 0; last_rst = 0; m_pe = 0; m_phase = 0; m_retry = 0; exp_vec = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        last_rst = cyc; m_phase = 0; m_pe = cyc; m_retry = 0; exp_vec = '0;
      end else begin
        cyc++;
        hist[0][cyc % HIST] = aib.tx_transfer_en;
        hist[1][cyc % HIST] = aib.rx_transfer_en;
        hist[2][cyc % HIST] = aib.fs_mac_rdy;
        xfer = raw(0, cyc - 2) && raw(1, cyc - 2);
        fall = raw(2, cyc - 3) && !raw(2, cyc - 2);
        d    = cyc - m_pe;
        nxt  = m_phase;
        lose = 1'b0;
        case (m_phase)
          0: nxt = 1;
          1: if (d == PWR_WAIT) nxt = 2;
          2: if (d == CFG_WAIT) nxt = 3;
          3: if (d == RST_WAIT) nxt = 4;
          4: if (xfer) nxt = 5; else if (d == TIMEOUT) lose = 1'b1;
          5: if (retrain || !xfer || fall) lose = 1'b1;
          6: if (d == RST_WAIT) nxt = 3;
          default: nxt = 7;
        endcase
        if (lose) begin
          if (m_retry == MAX_RETRY) nxt = 7;
          else begin nxt = 6; m_retry++; end
        end
        if (!start) begin nxt = 0; m_retry = 0; end
        if (nxt != m_phase) m_pe = cyc;
        m_phase = nxt;
        cd = (m_phase >= 2);
        ar = (m_phase >= 3 && m_phase <= 5);
        tx = (m_phase == 4 || m_phase == 5);
        rx = (m_phase == 5) || (m_phase == 4 && (ms_nsl || (cyc - m_pe) >= RXLOCK_DLY));
        exp_vec = {3'(m_phase), 2'(m_retry), cd, cd & ms_nsl, cd & !ms_nsl, ar, ar, tx, rx,
                   m_phase == 5, m_phase == 7};
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      checkOutput($sformatf("cycle_%0d", cyc), 32'(dut_vec()), 32'(exp_vec));
    end
  end

  initial begin : stim
    int n, rst_hold;
    logic role;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(dut_vec()), 32'(0));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] master bring-up, fs drop, retrain pulse");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_for("m_txlock", 0, 1'b1, 100, n);
    checkOutput("m_start_to_lock", 32'(n), 32'(43));
    checkOutput("m_rx_with_tx", 32'(aib.rx_lock_req), 32'(1));
    repeat (50) @(negedge clk);
    aib.tx_transfer_en = 1'b1; aib.rx_transfer_en = 1'b1;
    wait_for("m_linkup", 2, 1'b1, 20, n);
    checkOutput("m_lock_to_linkup", 32'(50 + n), 32'(53));
    checkOutput("m_detect_por", 32'({aib.device_detect, aib.por}), 32'(2'b10));
    repeat (5) @(negedge clk);
    aib.fs_mac_rdy = 1'b0;
    @(negedge clk);
    aib.fs_mac_rdy = 1'b1;
    wait_for("fs_retrain", 4, 1'b0, 20, n);
    checkOutput("fs_drop_to_retrain", 32'(1 + n), 32'(3));
    checkOutput("fs_retry_cnt", 32'(retry_cnt), 32'(1));
    checkOutput("fs_state", 32'(state), 32'(6));
    wait_for("fs_rstrel", 4, 1'b1, 40, n);
    checkOutput("fs_rst_low_cycles", 32'(n), 32'(12));
    wait_for("fs_relink", 2, 1'b1, 100, n);
    repeat ($urandom_range(3, 30)) @(negedge clk);
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
    wait_for("rt_relink", 2, 1'b1, 100, n);
    checkOutput("rt_retry_cnt", 32'(retry_cnt), 32'(2));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("m_teardown", 32'(dut_vec()), 32'(0));

    $display("[TB] slave bring-up");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_for("s_txlock", 0, 1'b1, 100, n);
    checkOutput("s_start_to_lock", 32'(n), 32'(43));
    wait_for("s_rxlock", 1, 1'b1, 100, n);
    checkOutput("s_tx_to_rx_lock", 32'(n), 32'(RXLOCK_DLY));
    checkOutput("s_detect_por", 32'({aib.device_detect, aib.por}), 32'(2'b01));
    repeat ($urandom_range(0, 200)) @(negedge clk);
    aib.tx_transfer_en = 1'b1;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    aib.rx_transfer_en = 1'b1;
    wait_for("s_linkup", 2, 1'b1, 20, n);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    $display("[TB] lock timeout to error");
    role = 1'($urandom_range(0, 1));
    applyStimulus(1'b1, 1'b0, role, 1'b0, 1'b0, 1'b1);
    wait_for("to_err", 3, 1'b1, 5000, n);
    checkOutput("to_start_to_err", 32'(n), 32'(4211));
    checkOutput("to_retry_cnt", 32'(retry_cnt), 32'(3));
    checkOutput("to_state", 32'(state), 32'(7));
    applyStimulus(1'b0, 1'b0, role, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("to_idle", 32'(dut_vec()), 32'(0));

    $display("[TB] reset in LOCK, start drop in RSTREL");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_for("rl_txlock", 0, 1'b1, 100, n);
    repeat ($urandom_range(0, 50)) @(negedge clk);
    rstn = 1'b0; start = 1'b0;
    #1;
    checkOutput("rl_async_reset", 32'(dut_vec()), 32'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_for("sd_rstrel", 4, 1'b1, 100, n);
    repeat (3) @(negedge clk);
    checkOutput("sd_in_rstrel", 32'(state), 32'(3));
    start = 1'b0;
    @(negedge clk);
    checkOutput("sd_start_drop", 32'(dut_vec()), 32'(0));

    $display("[TB] xfer on the timeout cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_for("sx_txlock", 0, 1'b1, 100, n);
    repeat (TIMEOUT - 3) @(negedge clk);
    aib.tx_transfer_en = 1'b1; aib.rx_transfer_en = 1'b1;
    wait_for("sx_linkup", 2, 1'b1, 10, n);
    checkOutput("sx_lock_to_linkup", 32'(TIMEOUT - 3 + n), 32'(TIMEOUT));
    checkOutput("sx_retry_cnt", 32'(retry_cnt), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    $display("[TB] random soak");
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      retrain = 1'b0;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rstn = 1'b1;
      end else if ($urandom_range(0, 1499) == 0) begin
        rstn = 1'b0;
        rst_hold = 2;
      end
      if (start) begin
        if ($urandom_range(0, 599) == 0) start = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        start = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        ms_nsl = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 79) == 0)  retrain = 1'b1;
      if ($urandom_range(0, 119) == 0) aib.tx_transfer_en = ~aib.tx_transfer_en;
      if ($urandom_range(0, 119) == 0) aib.rx_transfer_en = ~aib.rx_transfer_en;
      if ($urandom_range(0, 249) == 0) aib.fs_mac_rdy = ~aib.fs_mac_rdy;
    end
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
